// File: rtl/ddr100_pkg.sv
// Shared definitions for the DDR100 read-capture calibration engine:
// tap count, FSM states and the expected training beat.
package ddr100_pkg;

  localparam int NUM_TAPS = 12;
  localparam int MAX_DQ   = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_REQ,
    S_COLLECT,
    S_NEXT,
    S_ANALYZE,
    S_DONE
  } cal_state_t;

  // Returns {p0, p1}; odd beats swap the true and inverted pattern.
  function automatic logic [2*MAX_DQ-1:0] exp_beat(
    input logic [MAX_DQ-1:0] pat,
    input logic              odd
  );
    exp_beat = odd ? {~pat, pat} : {pat, ~pat};
  endfunction

endpackage

// File: rtl/ddr100_rd_cal_window.sv
// Serial longest-run finder over the 12-tap pass map.
// Ties resolve to the lowest-index run; no wrap-around.
module ddr100_rd_cal_window
  import ddr100_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [NUM_TAPS-1:0] i_map,
  output logic                o_ready,
  output logic                o_valid,
  output logic [3:0]          o_centre
);

  logic       r_run;
  logic       r_ready;
  logic [3:0] r_idx;
  logic [3:0] r_cur_len;
  logic [3:0] r_cur_start;
  logic [3:0] r_best_len;
  logic [3:0] r_best_start;

  logic [3:0] w_len;
  logic [3:0] w_start;
  logic [3:0] w_half;

  assign w_len   = r_cur_len + 4'd1;
  assign w_start = (r_cur_len == 4'd0) ? r_idx : r_cur_start;
  assign w_half  = (r_best_len - 4'd1) >> 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run        <= 1'b0;
      r_ready      <= 1'b0;
      r_idx        <= '0;
      r_cur_len    <= '0;
      r_cur_start  <= '0;
      r_best_len   <= '0;
      r_best_start <= '0;
    end else begin
      r_ready <= 1'b0;
      if (i_start) begin
        r_run        <= 1'b1;
        r_idx        <= '0;
        r_cur_len    <= '0;
        r_best_len   <= '0;
        r_best_start <= '0;
      end else if (r_run) begin
        if (i_map[r_idx]) begin
          r_cur_len   <= w_len;
          r_cur_start <= w_start;
          // strict compare keeps the earliest of equal runs
          if (w_len > r_best_len) begin
            r_best_len   <= w_len;
            r_best_start <= w_start;
          end
        end else begin
          r_cur_len <= '0;
        end
        r_idx <= r_idx + 4'd1;
        if (r_idx == 4'(NUM_TAPS-1)) begin
          r_run   <= 1'b0;
          r_ready <= 1'b1;
        end
      end
    end
  end

  assign o_ready  = r_ready;
  assign o_valid  = (r_best_len != 4'd0);
  assign o_centre = r_best_start + w_half;

endmodule

// File: rtl/ddr100_rd_cal.sv
// Read-capture calibration: sweeps the one-hot rsel window,
// checks a training burst per tap and centres on the widest pass run.
module ddr100_rd_cal
  import ddr100_pkg::*;
#(
  parameter int                  DQ_WIDTH    = 16,
  parameter int                  BURST       = 4,
  parameter int                  SETTLE      = 8,
  parameter int                  TIMEOUT     = 64,
  parameter int                  DEFAULT_TAP = 6,
  parameter logic [DQ_WIDTH-1:0] PATTERN     = 16'hA5C3
) (
  input  logic                clk100m,
  input  logic                phy_rst_n,
  input  logic                cal_start,
  output logic                busy,
  output logic                done,
  output logic                fail,
  output logic [NUM_TAPS-1:0] pass_map,
  output logic                rd_req,
  input  logic                rd_ack,
  input  logic                rd_valid,
  input  logic [DQ_WIDTH-1:0] rdata_p0,
  input  logic [DQ_WIDTH-1:0] rdata_p1,
  output logic [NUM_TAPS-1:0] rsel
);

  localparam int BW = $clog2(BURST + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [NUM_TAPS-1:0] DEF_SEL =
    NUM_TAPS'(1) << DEFAULT_TAP;
  localparam logic [MAX_DQ-1:0] LANE_MASK =
    MAX_DQ'({DQ_WIDTH{1'b1}});

  cal_state_t          r_state;
  logic [3:0]          r_tap;
  logic [SW-1:0]       r_set;
  logic [BW-1:0]       r_beat;
  logic [TW-1:0]       r_to;
  logic                r_err;
  logic                r_busy;
  logic                r_done;
  logic                r_fail;
  logic                r_rd_req;
  logic                r_win_start;
  logic [NUM_TAPS-1:0] r_map;
  logic [NUM_TAPS-1:0] r_rsel;

  logic [2*MAX_DQ-1:0] w_exp;
  logic [MAX_DQ-1:0]   w_diff0;
  logic [MAX_DQ-1:0]   w_diff1;
  logic                w_mis;
  logic                w_win_ready;
  logic                w_win_valid;
  logic [3:0]          w_win_centre;

  assign w_exp   = exp_beat(MAX_DQ'(PATTERN), r_beat[0]);
  assign w_diff0 = w_exp[2*MAX_DQ-1:MAX_DQ] ^ MAX_DQ'(rdata_p0);
  assign w_diff1 = w_exp[MAX_DQ-1:0] ^ MAX_DQ'(rdata_p1);
  assign w_mis   = |(w_diff0 & LANE_MASK) | |(w_diff1 & LANE_MASK);

  ddr100_rd_cal_window u_window (
    .clk      (clk100m),
    .rst_n    (phy_rst_n),
    .i_start  (r_win_start),
    .i_map    (r_map),
    .o_ready  (w_win_ready),
    .o_valid  (w_win_valid),
    .o_centre (w_win_centre)
  );

  always_ff @(posedge clk100m or negedge phy_rst_n) begin
    if (!phy_rst_n) begin
      r_state     <= S_IDLE;
      r_tap       <= '0;
      r_set       <= '0;
      r_beat      <= '0;
      r_to        <= '0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_rd_req    <= 1'b0;
      r_win_start <= 1'b0;
      r_map       <= '0;
      r_rsel      <= DEF_SEL;
    end else begin
      r_done      <= 1'b0;
      r_win_start <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (cal_start) begin
            r_state <= S_SETTLE;
            r_busy  <= 1'b1;
            r_tap   <= '0;
            r_set   <= '0;
            r_rsel  <= NUM_TAPS'(1);
            r_map   <= '0;
            r_fail  <= 1'b0;
          end
        end
        S_SETTLE: begin
          r_set <= r_set + SW'(1);
          if (r_set == SW'(SETTLE-1)) begin
            r_state  <= S_REQ;
            r_rd_req <= 1'b1;
          end
        end
        S_REQ: begin
          if (rd_ack) begin
            r_state  <= S_COLLECT;
            r_rd_req <= 1'b0;
            r_beat   <= '0;
            r_err    <= 1'b0;
            r_to     <= '0;
          end
        end
        S_COLLECT: begin
          r_to <= r_to + TW'(1);
          if (rd_valid) begin
            r_err  <= r_err | w_mis;
            r_beat <= r_beat + BW'(1);
          end
          if (rd_valid && r_beat == BW'(BURST-1)) begin
            r_state <= S_NEXT;
          end else if (r_to == TW'(TIMEOUT-1)) begin
            r_state <= S_NEXT;
            r_err   <= 1'b1;
          end
        end
        S_NEXT: begin
          r_map[r_tap] <= ~r_err;
          if (r_tap != 4'(NUM_TAPS-1)) begin
            r_tap   <= r_tap + 4'd1;
            r_rsel  <= NUM_TAPS'(1) << (r_tap + 4'd1);
            r_set   <= '0;
            r_state <= S_SETTLE;
          end else begin
            r_state     <= S_ANALYZE;
            r_win_start <= 1'b1;
          end
        end
        S_ANALYZE: begin
          if (w_win_ready) r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          if (w_win_valid) begin
            r_rsel <= NUM_TAPS'(1) << w_win_centre;
          end else begin
            r_rsel <= DEF_SEL;
            r_fail <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign fail     = r_fail;
  assign pass_map = r_map;
  assign rd_req   = r_rd_req;
  assign rsel     = r_rsel;

endmodule

// File: tb/tb_ddr100_rd_cal.sv
// Randomized bench for ddr100_rd_cal: a lane/controller model
// feeds bursts, a run-length reference predicts the outcome.
module tb_ddr100_rd_cal;

  localparam int          BURST = 4;
  localparam int          DEF   = 6;
  localparam logic [15:0] PAT   = 16'hA5C3;

  logic        clk100m = 1'b0;
  logic        phy_rst_n = 1'b0;
  logic        cal_start = 1'b0;
  logic        rd_ack = 1'b0;
  logic        rd_valid = 1'b0;
  logic [15:0] rdata_p0 = '0;
  logic [15:0] rdata_p1 = '0;
  logic        busy, done, fail, rd_req;
  logic [11:0] pass_map, rsel;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk100m = ~clk100m;

  ddr100_rd_cal dut (
    .clk100m   (clk100m),
    .phy_rst_n (phy_rst_n),
    .cal_start (cal_start),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .pass_map  (pass_map),
    .rd_req    (rd_req),
    .rd_ack    (rd_ack),
    .rd_valid  (rd_valid),
    .rdata_p0  (rdata_p0),
    .rdata_p1  (rdata_p1),
    .rsel      (rsel)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int tap_of(input logic [11:0] s);
    for (int i = 0; i < 12; i++)
      if (s == (12'(1) << i)) return i;
    return -1;
  endfunction

  // Longest run of ones by enumerating run starts; first wins ties.
  task automatic ref_cal(input logic [11:0] m, output logic [11:0] r,
                         output logic f);
    int best, bs, l;
    logic prev;
    best = 0; bs = 0; prev = 1'b0;
    for (int s = 0; s < 12; s++) begin
      if (m[s] && !prev) begin
        l = 0;
        while (s + l < 12 && m[s+l]) l++;
        if (l > best) begin best = l; bs = s; end
      end
      prev = m[s];
    end
    if (best == 0) begin
      r = 12'(1) << DEF; f = 1'b1;
    end else begin
      r = 12'(1) << (bs + (best - 1) / 2); f = 1'b0;
    end
  endtask

  task automatic send_beat(input int k, input bit bad, input int bi);
    logic [15:0] p0, p1;
    p0 = (k % 2 == 0) ? PAT : ~PAT;
    p1 = ~p0;
    if (bad) begin
      if (bi < 16) p0[bi] = ~p0[bi];
      else         p1[bi-16] = ~p1[bi-16];
    end
    rd_valid = 1'b1; rdata_p0 = p0; rdata_p1 = p1;
    @(negedge clk100m);
    rd_valid = 1'b0;
    rdata_p0 = 16'($urandom); rdata_p1 = 16'($urandom);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rsel"}, rsel, 12'(1) << DEF);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_fail"}, fail, 0);
    chk({tag, "_rd_req"}, rd_req, 0);
    chk({tag, "_map"}, pass_map, 0);
  endtask

  task automatic run_cal(input string nm, input logic [11:0] good,
                         input int drop, input int badbeat,
                         input int rst_tap);
    logic [11:0] em, er;
    logic ef;
    int cyc, tap, bb;
    bit fin, first, bad;
    em = good;
    if (drop >= 0) em[drop] = 1'b0;
    ref_cal(em, er, ef);
    @(negedge clk100m); cal_start = 1'b1;
    @(negedge clk100m); cal_start = 1'b0;
    chk({nm, "_busy_rise"}, busy, 1);
    first = 1; fin = 0; cyc = 0;
    while (!fin && cyc < 20000) begin
      @(negedge clk100m); cyc++;
      cal_start = 1'b0;
      if (done) begin
        fin = 1;
        chk({nm, "_busy_fall"}, busy, 0);
        chk({nm, "_map"}, pass_map, em);
        chk({nm, "_rsel"}, rsel, er);
        chk({nm, "_fail"}, fail, ef);
        @(negedge clk100m);
        chk({nm, "_done_pulse"}, done, 0);
        chk({nm, "_rsel_hold"}, rsel, er);
      end else if (rd_req) begin
        tap = tap_of(rsel);
        chk({nm, "_rsel_onehot"}, 32'(tap >= 0), 1);
        if (first) begin
          chk({nm, "_first_tap"}, rsel, 12'h001);
          chk({nm, "_map_clr"}, pass_map, 0);
          chk({nm, "_fail_clr"}, fail, 0);
          first = 0;
        end
        repeat ($urandom_range(0, 10)) begin
          chk({nm, "_rd_req_hold"}, rd_req, 1);
          @(negedge clk100m); cyc++;
        end
        rd_ack = 1'b1;
        @(negedge clk100m); cyc++;
        rd_ack = 1'b0;
        chk({nm, "_rd_req_drop"}, rd_req, 0);
        if (tap != drop) begin
          bb  = (badbeat >= 0) ? badbeat : int'($urandom_range(0, BURST-1));
          bad = (tap < 0) || !good[tap];
          for (int k = 0; k < BURST; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk100m);
            send_beat(k, bad && (k == bb), int'($urandom_range(0, 31)));
            if (tap == rst_tap && k == 1) begin
              #2 phy_rst_n = 1'b0;
              #1 chk_reset_vals({nm, "_midrst"});
              @(negedge clk100m); phy_rst_n = 1'b1;
              return;
            end
          end
        end
      end else if ($urandom_range(0, 15) == 0) begin
        cal_start = 1'b1;
      end
    end
    if (!fin) chk({nm, "_done_timeout"}, 0, 1);
  endtask

  initial begin
    logic [11:0] g;
    int dr;
    repeat (3) @(negedge clk100m);
    chk_reset_vals("reset");
    phy_rst_n = 1'b1;
    @(negedge clk100m);
    chk_reset_vals("idle");

    repeat (5) begin
      rd_valid = 1'b1;
      rdata_p0 = 16'($urandom); rdata_p1 = 16'($urandom);
      @(negedge clk100m);
    end
    rd_valid = 1'b0;
    chk_reset_vals("idle_valid");

    run_cal("mid", 12'h1F8, -1, -1, -1);
    run_cal("two_runs", 12'h3C6, -1, -1, -1);
    run_cal("tie", 12'h603, -1, -1, -1);
    run_cal("all_bad", 12'h000, -1, 2, -1);
    repeat (4) @(negedge clk100m);
    chk("fail_sticky", fail, 1);
    run_cal("timeout", 12'hFFF, 4, -1, -1);
    run_cal("rst_run", 12'h0F0, -1, -1, 7);
    run_cal("restart", 12'h0F0, -1, -1, -1);
    for (int i = 0; i < 5; i++) begin
      g  = 12'($urandom);
      dr = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 11)) : -1;
      run_cal("rand", g, dr, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ddr100_rd_cal.md
# ddr100_rd_cal

Read-capture calibration engine for the 100 MHz DDR PHY. It drives the 12-bit one-hot `rsel` window select shared by every DQ lane and sweeps all 12 capture positions. At each position it requests a read of a known training burst and checks the returned `rdata_p0`/`rdata_p1` lanes. It then programs `rsel` to the centre of the longest passing run. It sits between the memory controller's init sequencer, which starts it and serves its read requests, and the DQ lane instances.

## Interface
- `DQ_WIDTH`, default 16: number of DQ lanes checked.
- `BURST`, default 4: beats (p0/p1 pairs) per training read.
- `SETTLE`, default 8: cycles to wait after changing `rsel` before issuing a read.
- `TIMEOUT`, default 64: max cycles from `rd_ack` to the final beat.
- `DEFAULT_TAP`, default 6: tap used at reset and after a failed calibration.
- `PATTERN`, default 16'hA5C3: training word (low `DQ_WIDTH` bits used).

Ports:
- `clk100m` in 1: sole clock.
- `phy_rst_n` in 1: asynchronous, active-low reset.
- `cal_start` in 1: single-cycle pulse that starts calibration; ignored while `busy`.
- `busy` out 1: calibration in progress.
- `done` out 1: one-cycle pulse at completion.
- `fail` out 1: sticky until the next `cal_start`; no tap passed.
- `pass_map` out 12: per-tap pass result of the last run.
- `rd_req` out 1: request a training read.
- `rd_ack` in 1: controller accepted the request.
- `rd_valid` in 1: beat valid on `rdata_p0`/`rdata_p1`.
- `rdata_p0` in DQ_WIDTH: phase-0 data from the lanes.
- `rdata_p1` in DQ_WIDTH: phase-1 data from the lanes.
- `rsel` out 12: one-hot capture select to all lanes.

## Operation
- Expected data for beat k (0-based):
  - even k: p0 = `PATTERN`, p1 = ~`PATTERN`.
  - odd k: p0 = ~`PATTERN`, p1 = `PATTERN`.
- States and transitions:
  - IDLE → SETTLE on `cal_start`. Tap counter = 0, `rsel` = 1<<0, `pass_map` cleared, `fail` cleared.
  - SETTLE: counts `SETTLE` cycles, then → REQ.
  - REQ: `rd_req` = 1 until the cycle `rd_ack` = 1, then → COLLECT. Beat counter = 0, tap error flag = 0, timeout counter = 0.
  - COLLECT: on each `rd_valid`, compare the full p0/p1 against expected and OR any mismatch into the error flag. After beat `BURST`-1 → NEXT. If the timeout counter reaches `TIMEOUT` → NEXT with the error flag forced to 1.
  - NEXT: `pass_map[tap]` = ~error.
    - tap < 11: tap+1, `rsel` = 1<<tap, → SETTLE.
    - otherwise → ANALYZE.
  - ANALYZE: serial scan over 12 cycles (one tap per cycle) tracking the longest contiguous run of 1s, with no wrap-around. Ties go to the lowest-index run. Then → DONE.
  - DONE: if no run exists, `fail` = 1 and `rsel` = 1<<`DEFAULT_TAP`. Otherwise `rsel` = 1<<(start + (len-1)/2), integer division. Pulse `done`, → IDLE.
- `rd_valid` outside COLLECT is ignored. `cal_start` while `busy` is ignored.

## Timing
- Reset values:
  - `rsel` = 1<<`DEFAULT_TAP`.
  - `busy`, `done`, `fail`, `rd_req` = 0.
  - `pass_map` = 0.
- Reset mid-run returns immediately to IDLE with all outputs at their reset values.
- `busy` rises the cycle after `cal_start`. It falls in the same cycle `done` pulses.
- `rsel` changes only in NEXT/DONE and is registered; it is stable for at least `SETTLE` cycles before `rd_req` rises.
- Beats need not be contiguous. The comparison is registered, and the tap result is final at NEXT.
- Nominal run length: 12 × (`SETTLE` + 1 + ack latency + beats + 1) + 12 + 1 cycles.

## Structure
- Shared package `ddr100_pkg`: `NUM_TAPS` = 12, the state enum, and the expected-beat function (pattern, beat index → {p0, p1}).
- One sub-module, `ddr100_rd_cal_window`: takes the 12-bit map and returns the centre tap and a valid flag. It may be combinational or serial; the top-level FSM waits on its `ready`.

## Test plan
- Lane model with passing taps 3..8 → `pass_map` = 12'h1F8, final `rsel` = 1<<5, `fail` = 0, `done` pulses once.
- Passing taps {1, 2} and {6, 7, 8, 9} → `rsel` = 1<<7. Equal runs {0, 1} and {9, 10} → `rsel` = 1<<0.
- All taps corrupt one bit on beat 2 → `pass_map` = 0, `fail` = 1, `rsel` = 1<<6.
- Controller never asserts `rd_valid` for tap 4 → tap 4 fails after `TIMEOUT` cycles; the remaining taps are processed normally.
- `phy_rst_n` asserted in COLLECT at tap 7 → outputs at reset values immediately. A new `cal_start` then restarts at tap 0 with `pass_map` = 0.
- `cal_start` pulsed while `busy`, and `rd_valid` pulsed in IDLE → no effect on state or results; `rd_req` is held until `rd_ack` under random ack delays of 0–10 cycles.
